// File: rtl/adc_cic_pkg.sv
// ---------------------------------------------------------------------------
// adc_cic_pkg
// Shared defaults and width helpers for the adc_cic_decim CIC decimator.
//   IW_DEF / OW_DEF       : default input / output sample widths
//   N_DEF / LOG2R_DEF     : default stage count and log2 decimation ratio
//   cic_aw()              : accumulator width, IW + N*LOG2R (covers R^N gain)
//   cic_sh()              : LSBs dropped by the scaler, AW - OW
//   acc_t                 : accumulator type for the default configuration
// ---------------------------------------------------------------------------
package adc_cic_pkg;

  localparam int IW_DEF    = 16;
  localparam int OW_DEF    = 16;
  localparam int N_DEF     = 3;
  localparam int LOG2R_DEF = 4;

  function automatic int cic_aw(input int iw, input int n, input int log2r);
    return iw + n * log2r;
  endfunction

  function automatic int cic_sh(input int aw, input int ow);
    return aw - ow;
  endfunction

  localparam int AW_DEF = cic_aw(IW_DEF, N_DEF, LOG2R_DEF);

  typedef logic signed [AW_DEF-1:0] acc_t;

endpackage

// File: rtl/adc_cic_decim_comb.sv
// ---------------------------------------------------------------------------
// cic_comb_stage
// One registered differentiator of the CIC comb section: y = x - x_prev,
// where x_prev is the input captured at the previous enable. The delay and
// output only move on en_i, so the delay is one decimated sample deep.
//   clk, rst : clock, synchronous active-high reset
//   en_i     : decimated-sample strobe (also the incoming valid)
//   x_i      : AW-bit modular input
//   vld_o    : en_i delayed by one cycle (valid for y_o)
//   y_o      : AW-bit modular difference
// ---------------------------------------------------------------------------
module cic_comb_stage #(
  parameter int AW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [AW-1:0] x_i,
  output logic          vld_o,
  output logic [AW-1:0] y_o
);

  logic [AW-1:0] dly_q;
  logic [AW-1:0] y_q;
  logic          vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q <= '0;
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= en_i;
      if (en_i) begin
        y_q   <= x_i - dly_q;
        dly_q <= x_i;
      end
    end
  end

  assign vld_o = vld_q;
  assign y_o   = y_q;

endmodule

// File: rtl/adc_cic_decim.sv
// ---------------------------------------------------------------------------
// adc_cic_decim
// N-stage CIC decimator, ratio R = 2^LOG2R, with a valid/ready output
// register and a sticky overrun flag.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : one-cycle strobe qualifying in_data (may be held high)
//   in_data    : signed IW-bit ADC sample
//   out_valid  : output register holds an unconsumed result
//   out_ready  : consumer accepts out_data when out_valid && out_ready
//   out_data   : signed OW-bit decimated sample
//   overrun    : sticky, set when an unconsumed result was overwritten
// Build option CIC_ROUND_EN: round half up before dropping LSBs and saturate
// at the positive full scale. Without it the scaler is a plain floor shift.
// Latency: out_valid rises N+2 edges after the edge that takes the
// decimating sample (handoff + N-1 further combs, scaler, output register).
// ---------------------------------------------------------------------------
module adc_cic_decim
  import adc_cic_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int OW    = OW_DEF,
  parameter int N     = N_DEF,
  parameter int LOG2R = LOG2R_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          overrun
);

  localparam int AW = cic_aw(IW, N, LOG2R);
  localparam int SH = cic_sh(AW, OW);

  // Integrators: stage k adds the pre-update value of stage k-1.
  logic [AW-1:0] integ_q [N];
  logic [AW-1:0] integ_d [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      integ_d[k] = integ_q[k];
    end
    if (in_valid) begin
      integ_d[0] = integ_q[0] + {{(AW-IW){in_data[IW-1]}}, in_data};
      for (int k = 1; k < N; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
  end

  logic [LOG2R-1:0] phase_q;
  logic [LOG2R-1:0] phase_d;
  logic             strobe;
  logic             strobe_q;

  assign strobe  = in_valid && (phase_q == '1);
  assign phase_d = in_valid ? phase_q + LOG2R'(1) : phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
      end
      phase_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= integ_d[k];
      end
      phase_q  <= phase_d;
      strobe_q <= strobe;
    end
  end

  // The registered last integrator already holds the post-update value when
  // strobe_q is high, so it feeds the first comb directly.
  logic [AW-1:0] comb_x [N+1];
  logic          comb_v [N+1];

  assign comb_x[0] = integ_q[N-1];
  assign comb_v[0] = strobe_q;

  for (genvar g = 0; g < N; g++) begin : g_comb
    cic_comb_stage #(
      .AW (AW)
    ) u_comb (
      .clk   (clk),
      .rst   (rst),
      .en_i  (comb_v[g]),
      .x_i   (comb_x[g]),
      .vld_o (comb_v[g+1]),
      .y_o   (comb_x[g+1])
    );
  end

  logic [AW-1:0] comb_y;
  logic [OW-1:0] scale_d;

  assign comb_y = comb_x[N];

`ifdef CIC_ROUND_EN
  localparam logic [AW:0] HALF = {{AW{1'b0}}, 1'b1} << (SH - 1);
  localparam logic [OW:0] OMAX = {2'b00, {(OW-1){1'b1}}};

  logic [AW:0] rnd_sum;
  logic [OW:0] rnd_sh;

  // One guard bit keeps the rounding add from wrapping at positive full scale.
  always_comb begin
    rnd_sum = {comb_y[AW-1], comb_y} + HALF;
    rnd_sh  = rnd_sum[AW:SH];
    scale_d = ($signed(rnd_sh) > $signed(OMAX)) ? OMAX[OW-1:0] : rnd_sh[OW-1:0];
  end
`else
  assign scale_d = comb_y[AW-1:SH];
`endif

  logic [OW-1:0] scale_q;
  logic          scale_vld_q;
  logic [OW-1:0] out_data_q;
  logic          out_valid_q;
  logic          overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scale_q     <= '0;
      scale_vld_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      scale_vld_q <= comb_v[N];
      if (comb_v[N]) begin
        scale_q <= scale_d;
      end
      if (scale_vld_q) begin
        out_data_q  <= scale_q;
        out_valid_q <= 1'b1;
        if (out_valid_q && !out_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;

endmodule
